stepper_cmd_ctrl: RTL and testbench

Command sequencer between the UART byte receiver and the four stepper channel generators. It parses framed command packets from the received byte stream and configures each channel's direction, step count and step period. It issues move and stop strobes to each channel, holding a move until that channel reports idle. It also reports framing, overrun and inter-byte timeout errors.

---
 rtl/stepper_cmd_ctrl_pkg.sv | 27 ++
 rtl/stepper_cmd_ctrl_if.sv | 27 ++
 rtl/stepper_cmd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_stepper_cmd_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_cmd_ctrl_pkg.sv
// Shared constants and types for the stepper command sequencer.
package stepper_cmd_pkg;

   localparam int unsigned CHANNELS = 4;
   localparam logic [3:0]  SYNC     = 4'hA;

   typedef enum logic [1:0] {
      OP_MOVE       = 2'b00,
      OP_STOP       = 2'b01,
      OP_SET_PERIOD = 2'b10,
      OP_CLEAR_ERR  = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PAY_HI,
      S_PAY_LO,
      S_COMMIT,
      S_WAIT
   } state_t;

   // A zero period would stall a channel generator, so it is stored as 1.
   function automatic logic [15:0] clamp_period(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

endpackage

// File: rtl/stepper_cmd_ctrl_if.sv
// Byte-stream input and per-channel motor control bundle.
interface stepper_cmd_ctrl_if;
   import stepper_cmd_pkg::*;

   logic [7:0]               rx_byte;
   logic                     rbyte_ready;
   logic [CHANNELS-1:0]      mot_busy;
   logic [CHANNELS-1:0]      mot_dir;
   logic [CHANNELS*15-1:0]   mot_steps;
   logic [CHANNELS*16-1:0]   mot_period;
   logic [CHANNELS-1:0]      mot_load;
   logic [CHANNELS-1:0]      mot_stop;
   logic [2:0]               err;

   // Byte source and channel generators side.
   modport master (
      output rx_byte, rbyte_ready, mot_busy,
      input  mot_dir, mot_steps, mot_period, mot_load, mot_stop, err
   );

   // Command sequencer side.
   modport slave (
      input  rx_byte, rbyte_ready, mot_busy,
      output mot_dir, mot_steps, mot_period, mot_load, mot_stop, err
   );

endinterface

// File: rtl/stepper_cmd_ctrl.sv
// Parses framed command packets from the UART byte stream and drives
// direction, step count, period, move and stop strobes for four channels.
module stepper_cmd_ctrl
   import stepper_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT        = 80000,
   parameter logic [15:0] DEFAULT_PERIOD = 16'd8000
)(
   input  logic               clk,
   input  logic               reset,
   stepper_cmd_ctrl_if.slave  bus
);

   localparam int unsigned    TCW   = $clog2(TIMEOUT) + 1;
   localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT - 1);

   state_t                  r_state;
   logic [1:0]              r_idx;
   opcode_t                 r_op;
   logic [7:0]              r_hi;
   logic [7:0]              r_lo;
   logic [TCW-1:0]          r_tcnt;
   logic [CHANNELS-1:0]     r_dir;
   logic [CHANNELS*15-1:0]  r_steps;
   logic [CHANNELS*16-1:0]  r_period;
   logic [CHANNELS-1:0]     r_load;
   logic [CHANNELS-1:0]     r_stop;
   logic [2:0]              r_err;

   logic                    w_sync_ok;
   logic [1:0]              w_hidx;
   opcode_t                 w_hop;
   logic                    w_is_stop;
   logic                    w_stop_own;
   logic [15:0]             w_payload;
   logic                    w_in_payload;
   logic                    w_timeout;
   logic                    w_busy_idx;
   logic [2:0]              w_err_set;
   logic                    w_err_clr;

   assign w_sync_ok    = (bus.rx_byte[7:4] == SYNC);
   assign w_hidx       = bus.rx_byte[3:2];
   assign w_hop        = opcode_t'(bus.rx_byte[1:0]);
   assign w_is_stop    = bus.rbyte_ready && w_sync_ok && (w_hop == OP_STOP);
   assign w_stop_own   = w_is_stop && (w_hidx == r_idx);
   assign w_payload    = {r_hi, r_lo};
   assign w_in_payload = (r_state == S_PAY_HI) || (r_state == S_PAY_LO);
   assign w_timeout    = w_in_payload && !bus.rbyte_ready && (r_tcnt == TLAST);
   assign w_busy_idx   = bus.mot_busy[r_idx];

   assign bus.mot_dir    = r_dir;
   assign bus.mot_steps  = r_steps;
   assign bus.mot_period = r_period;
   assign bus.mot_load   = r_load;
   assign bus.mot_stop   = r_stop;
   assign bus.err        = r_err;

   // Error set/clear decode; a byte taken in COMMIT is silently dropped.
   always_comb begin
      w_err_set = '0;
      w_err_clr = 1'b0;
      if (bus.rbyte_ready) begin
         if (r_state == S_IDLE) begin
            if (!w_sync_ok)
               w_err_set[0] = 1'b1;
            else if (w_hop == OP_CLEAR_ERR)
               w_err_clr = 1'b1;
         end else if (r_state == S_WAIT && !w_is_stop) begin
            w_err_set[1] = 1'b1;
         end
      end
      if (w_timeout)
         w_err_set[2] = 1'b1;
   end

   // Command FSM with register file, timeout counter and registered strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_op     <= OP_MOVE;
         r_hi     <= '0;
         r_lo     <= '0;
         r_tcnt   <= '0;
         r_dir    <= '0;
         r_steps  <= '0;
         r_period <= {CHANNELS{DEFAULT_PERIOD}};
         r_load   <= '0;
         r_stop   <= '0;
         r_err    <= '0;
      end else begin
         r_load <= '0;
         r_stop <= '0;
         r_err  <= (w_err_clr ? 3'b000 : r_err) | w_err_set;

         case (r_state)
            S_IDLE: begin
               r_tcnt <= '0;
               if (bus.rbyte_ready && w_sync_ok) begin
                  case (w_hop)
                     OP_STOP: r_stop[w_hidx] <= 1'b1;
                     OP_MOVE, OP_SET_PERIOD: begin
                        r_idx   <= w_hidx;
                        r_op    <= w_hop;
                        r_state <= S_PAY_HI;
                     end
                     default: ;
                  endcase
               end
            end

            S_PAY_HI: begin
               if (bus.rbyte_ready) begin
                  r_hi    <= bus.rx_byte;
                  r_tcnt  <= '0;
                  r_state <= S_PAY_LO;
               end else if (w_timeout) begin
                  r_tcnt  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt  <= r_tcnt + 1'b1;
               end
            end

            S_PAY_LO: begin
               if (bus.rbyte_ready) begin
                  r_lo    <= bus.rx_byte;
                  r_tcnt  <= '0;
                  r_state <= S_COMMIT;
               end else if (w_timeout) begin
                  r_tcnt  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt  <= r_tcnt + 1'b1;
               end
            end

            S_COMMIT: begin
               r_tcnt <= '0;
               if (r_op == OP_SET_PERIOD) begin
                  r_period[r_idx*16 +: 16] <= clamp_period(w_payload);
                  r_state <= S_IDLE;
               end else if (w_payload[14:0] == 15'd0) begin
                  r_state <= S_IDLE;
               end else if (!w_busy_idx) begin
                  r_dir[r_idx]             <= w_payload[15];
                  r_steps[r_idx*15 +: 15]  <= w_payload[14:0];
                  r_load[r_idx]            <= 1'b1;
                  r_state                  <= S_IDLE;
               end else begin
                  r_state <= S_WAIT;
               end
            end

            S_WAIT: begin
               r_tcnt <= '0;
               if (w_is_stop)
                  r_stop[w_hidx] <= 1'b1;
               // A stop aimed at the waiting channel cancels the move even
               // if busy drops in the same cycle.
               if (w_stop_own) begin
                  r_state <= S_IDLE;
               end else if (!w_busy_idx) begin
                  r_dir[r_idx]             <= w_payload[15];
                  r_steps[r_idx*15 +: 15]  <= w_payload[14:0];
                  r_load[r_idx]            <= 1'b1;
                  r_state                  <= S_IDLE;
               end
            end

            default: begin
               r_tcnt  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stepper_cmd_ctrl.sv
// Directed bench for the stepper command sequencer.
module tb_stepper_cmd_ctrl;

   localparam int unsigned TO  = 40;
   localparam logic [15:0] DEF = 16'h1F40;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   stepper_cmd_ctrl_if bus ();

   stepper_cmd_ctrl #(
      .TIMEOUT        (TO),
      .DEFAULT_PERIOD (DEF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Byte is sampled on the edge at which this task returns (+1).
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.rx_byte     = b;
      bus.rbyte_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rbyte_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      checks++;
      if (bus.mot_dir !== 4'h0) begin
         errors++; $display("FAIL reset_dir got %h want 0", bus.mot_dir);
      end
      checks++;
      if (bus.mot_steps !== 60'h0) begin
         errors++; $display("FAIL reset_steps got %h want 0", bus.mot_steps);
      end
      checks++;
      if (bus.mot_period !== {4{DEF}}) begin
         errors++; $display("FAIL reset_period got %h want %h", bus.mot_period, {4{DEF}});
      end
      checks++;
      if ({bus.mot_load, bus.mot_stop, bus.err} !== 11'h0) begin
         errors++; $display("FAIL reset_strobes got %h want 0", {bus.mot_load, bus.mot_stop, bus.err});
      end
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_move_idle;
      bus.mot_busy = 4'h0;
      send_byte(8'hA0); send_byte(8'h80); send_byte(8'h64);
      checks++;
      if (bus.mot_load !== 4'h0) begin
         errors++; $display("FAIL move_early_load got %b want 0000", bus.mot_load);
      end
      tick(1);
      checks++;
      if (bus.mot_load !== 4'b0001) begin
         errors++; $display("FAIL move_load got %b want 0001", bus.mot_load);
      end
      checks++;
      if (bus.mot_dir[0] !== 1'b1 || bus.mot_steps[14:0] !== 15'd100) begin
         errors++; $display("FAIL move_data got dir %b steps %0d want dir 1 steps 100",
                            bus.mot_dir[0], bus.mot_steps[14:0]);
      end
      tick(1);
      checks++;
      if (bus.mot_load !== 4'h0) begin
         errors++; $display("FAIL move_load_width got %b want 0000", bus.mot_load);
      end
   endtask

   task automatic test_set_period;
      send_byte(8'hA6); send_byte(8'h01); send_byte(8'hF4);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++;
         if (bus.mot_load !== 4'h0) begin
            errors++; $display("FAIL period_no_load got %b want 0000", bus.mot_load);
         end
      end
      checks++;
      if (bus.mot_period[31:16] !== 16'd500) begin
         errors++; $display("FAIL period_500 got %0d want 500", bus.mot_period[31:16]);
      end
      send_byte(8'hA6); send_byte(8'h00); send_byte(8'h00);
      tick(2);
      checks++;
      if (bus.mot_period[31:16] !== 16'd1) begin
         errors++; $display("FAIL period_zero got %0d want 1", bus.mot_period[31:16]);
      end
      checks++;
      if (bus.mot_period[15:0] !== DEF) begin
         errors++; $display("FAIL period_other got %h want %h", bus.mot_period[15:0], DEF);
      end
   endtask

   task automatic test_stop;
      send_byte(8'hA5);
      checks++;
      if (bus.mot_stop !== 4'b0010) begin
         errors++; $display("FAIL stop_pulse got %b want 0010", bus.mot_stop);
      end
      tick(1);
      checks++;
      if (bus.mot_stop !== 4'b0000) begin
         errors++; $display("FAIL stop_width got %b want 0000", bus.mot_stop);
      end
   endtask

   task automatic test_wait_release;
      bus.mot_busy = 4'b0100;
      send_byte(8'hA8); send_byte(8'h00); send_byte(8'h0A);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checks++;
         if (bus.mot_load !== 4'h0) begin
            errors++; $display("FAIL wait_hold got %b want 0000", bus.mot_load);
         end
      end
      bus.mot_busy = 4'b0000;
      checks++;
      if (bus.mot_load !== 4'h0) begin
         errors++; $display("FAIL wait_release_early got %b want 0000", bus.mot_load);
      end
      tick(1);
      checks++;
      if (bus.mot_load !== 4'b0100 || bus.mot_steps[44:30] !== 15'd10 || bus.mot_dir[2] !== 1'b0) begin
         errors++; $display("FAIL wait_release got load %b steps %0d dir %b want 0100 10 0",
                            bus.mot_load, bus.mot_steps[44:30], bus.mot_dir[2]);
      end
      tick(1);
      checks++;
      if (bus.mot_load !== 4'h0) begin
         errors++; $display("FAIL wait_release_width got %b want 0000", bus.mot_load);
      end
   endtask

   task automatic test_wait_bytes;
      bus.mot_busy = 4'b0100;
      send_byte(8'hA8); send_byte(8'h00); send_byte(8'h05);
      tick(2);
      send_byte(8'h33);
      checks++;
      if (bus.err !== 3'b010) begin
         errors++; $display("FAIL wait_overrun got %b want 010", bus.err);
      end
      send_byte(8'hAD);
      checks++;
      if (bus.mot_stop !== 4'b1000) begin
         errors++; $display("FAIL wait_stop_other got %b want 1000", bus.mot_stop);
      end
      send_byte(8'h33);
      checks++;
      if (bus.err !== 3'b010) begin
         errors++; $display("FAIL wait_still got %b want 010", bus.err);
      end
      send_byte(8'hA9);
      checks++;
      if (bus.mot_stop !== 4'b0100) begin
         errors++; $display("FAIL wait_stop_own got %b want 0100", bus.mot_stop);
      end
      bus.mot_busy = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         checks++;
         if (bus.mot_load !== 4'h0) begin
            errors++; $display("FAIL wait_cancel got %b want 0000", bus.mot_load);
         end
      end
      checks++;
      if (bus.mot_steps[44:30] !== 15'd10) begin
         errors++; $display("FAIL wait_cancel_steps got %0d want 10", bus.mot_steps[44:30]);
      end
   endtask

   task automatic test_sync_timeout;
      send_byte(8'hAF);
      checks++;
      if (bus.err !== 3'b000) begin
         errors++; $display("FAIL clear_err got %b want 000", bus.err);
      end
      send_byte(8'h55);
      checks++;
      if (bus.err !== 3'b001) begin
         errors++; $display("FAIL bad_sync got %b want 001", bus.err);
      end
      send_byte(8'hA0);
      tick(TO - 1);
      checks++;
      if (bus.err !== 3'b001) begin
         errors++; $display("FAIL timeout_early got %b want 001", bus.err);
      end
      tick(1);
      checks++;
      if (bus.err !== 3'b101) begin
         errors++; $display("FAIL timeout got %b want 101", bus.err);
      end
      send_byte(8'hA4); send_byte(8'h00); send_byte(8'h03);
      tick(1);
      checks++;
      if (bus.mot_load !== 4'b0010 || bus.mot_steps[29:15] !== 15'd3) begin
         errors++; $display("FAIL after_timeout got load %b steps %0d want 0010 3",
                            bus.mot_load, bus.mot_steps[29:15]);
      end
      send_byte(8'hAF);
      checks++;
      if (bus.err !== 3'b000) begin
         errors++; $display("FAIL clear_all got %b want 000", bus.err);
      end
   endtask

   task automatic test_byte_beats_timeout;
      send_byte(8'hA0);
      tick(TO - 2);
      send_byte(8'h12);
      tick(TO - 2);
      send_byte(8'h34);
      checks++;
      if (bus.err !== 3'b000) begin
         errors++; $display("FAIL byte_wins got %b want 000", bus.err);
      end
      tick(1);
      checks++;
      if (bus.mot_load !== 4'b0001 || bus.mot_steps[14:0] !== 15'h1234 || bus.mot_dir[0] !== 1'b0) begin
         errors++; $display("FAIL byte_wins_move got load %b steps %h dir %b want 0001 1234 0",
                            bus.mot_load, bus.mot_steps[14:0], bus.mot_dir[0]);
      end
   endtask

   task automatic test_reset_in_wait;
      bus.mot_busy = 4'b1000;
      send_byte(8'hAC); send_byte(8'h00); send_byte(8'h07);
      tick(2);
      send_byte(8'h33);
      checks++;
      if (bus.err !== 3'b010) begin
         errors++; $display("FAIL rst_wait_pre got %b want 010", bus.err);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.mot_dir !== 4'h0 || bus.mot_steps !== 60'h0 || bus.mot_period !== {4{DEF}}) begin
         errors++; $display("FAIL rst_wait_regs got dir %h steps %h period %h want 0 0 %h",
                            bus.mot_dir, bus.mot_steps, bus.mot_period, {4{DEF}});
      end
      checks++;
      if ({bus.mot_load, bus.mot_stop, bus.err} !== 11'h0) begin
         errors++; $display("FAIL rst_wait_strobes got %h want 0", {bus.mot_load, bus.mot_stop, bus.err});
      end
      tick(2);
      reset = 1'b0;
      bus.mot_busy = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         checks++;
         if (bus.mot_load !== 4'h0) begin
            errors++; $display("FAIL rst_wait_noload got %b want 0000", bus.mot_load);
         end
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b1;
      bus.rx_byte     = 8'h00;
      bus.rbyte_ready = 1'b0;
      bus.mot_busy    = 4'h0;
      test_reset();
      test_move_idle();
      test_set_period();
      test_stop();
      test_wait_release();
      test_wait_bytes();
      test_sync_timeout();
      test_byte_beats_timeout();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
